pl_hazard_ctrl: RTL and testbench

Sequential hazard/forwarding controller for the 5-stage RV32IM pipeline. It replaces the purely combinational forwarding/load-use logic in the control unit and adds four things: a parametrised load-use penalty, tracking of one outstanding multi-cycle mul/div (MD) operation, branch flush generation, and a stall performance counter. It sits beside the ID stage and drives the PC/IF-ID write enable, the ID-to-EXE bubble, the IF-ID flush, and the operand-forwarding muxes.

---
 rtl/pl_hazard_ctrl_pkg.sv | 15 +
 rtl/pl_hazard_ctrl_fwd_sel.sv | 29 ++
 rtl/pl_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pl_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pl_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pl_pkg;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMO  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_WB   = 2'd2
  } md_state_e;
endpackage

// File: rtl/pl_hazard_ctrl_fwd_sel.sv
// Per-operand forward selector: youngest producer wins, x0 never forwards.
module pl_fwd_sel
  import pl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LD_EXTRA = 0
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              e_wreg,
  input  logic              e_m2reg,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  output logic [1:0]        fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (rs_used && rs != '0) begin
      if (e_wreg && !e_m2reg && e_rd == rs) fwd = FWD_EALU;
      else if (m_wreg && m_rd == rs) begin
        // With the extra load stage, load data is only taken from the regfile.
        if (!m_m2reg)           fwd = FWD_MALU;
        else if (LD_EXTRA == 0) fwd = FWD_MMO;
      end
    end
  end
endmodule

// File: rtl/pl_hazard_ctrl.sv
// Hazard/forwarding controller: load-use and MD stalls, branch flush,
// one outstanding multi-cycle mul/div, saturating stall counter.
module pl_hazard_ctrl
  import pl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MD_LAT   = 8,
  parameter int LD_EXTRA = 0,
  parameter int SCNT_W   = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_wreg,
  input  logic              d_md,
  input  logic [REG_AW-1:0] e_rd,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              e_wreg,
  input  logic              e_m2reg,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  input  logic              br_taken,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir,
  output logic              d_bubble,
  output logic              f_flush,
  output logic              md_start,
  output logic              md_busy,
  output logic [REG_AW-1:0] md_rd,
  output logic              md_wb,
  output logic [SCNT_W-1:0] stall_cnt
);
  localparam int CNT_W = 6;

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             used;
  logic [1:0][1:0]        fwd;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              md_busy_q, md_busy_d;
  logic              md_wb_q, md_wb_d;

  logic md_act, ld_haz, md_raw, md_waw, md_struct, stall;

  assign rs   = {d_rs2, d_rs1};
  assign used = {d_use2, d_use1};
  assign fwda = fwd[0];
  assign fwdb = fwd[1];

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    pl_fwd_sel #(.REG_AW(REG_AW), .LD_EXTRA(LD_EXTRA)) u_sel (
      .rs(rs[i]), .rs_used(used[i]),
      .e_rd(e_rd), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
      .m_rd(m_rd), .m_wreg(m_wreg), .m_m2reg(m_m2reg),
      .fwd(fwd[i])
    );
  end

  function automatic logic hit(input logic u, input logic [REG_AW-1:0] r,
                               input logic [REG_AW-1:0] rd);
    return u && r != '0 && r == rd;
  endfunction

  // md_raw covers the WB cycle too: the regfile does not write through.
  always_comb begin
    md_act = state_q != MD_IDLE;
    ld_haz = 1'b0;
    md_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_haz = ld_haz | (e_wreg & e_m2reg & hit(used[i], rs[i], e_rd));
      if (LD_EXTRA != 0)
        ld_haz = ld_haz | (m_wreg & m_m2reg & hit(used[i], rs[i], m_rd));
      md_raw = md_raw | (md_act & hit(used[i], rs[i], md_rd_q));
    end
    md_waw    = md_act & d_wreg & (d_rd == md_rd_q) & (d_rd != '0);
    md_struct = d_md & md_act;
    stall     = ld_haz | md_raw | md_waw | md_struct;
  end

  assign wpcir    = br_taken | ~stall;
  assign d_bubble = br_taken | stall;
  assign f_flush  = br_taken;
  assign md_start = d_md & ~stall & ~br_taken;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    scnt_d  = scnt_q;
    case (state_q)
      MD_IDLE: if (md_start) begin
        state_d = MD_BUSY;
        cnt_d   = CNT_W'(MD_LAT - 1);
        md_rd_d = d_rd;
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_WB;
      end
      MD_WB:   state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (stall && !br_taken && scnt_q != {SCNT_W{1'b1}})
      scnt_d = scnt_q + SCNT_W'(1);
    md_busy_d = state_d != MD_IDLE;
    md_wb_d   = state_d == MD_WB;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      md_rd_q   <= '0;
      scnt_q    <= '0;
      md_busy_q <= 1'b0;
      md_wb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_rd_q   <= md_rd_d;
      scnt_q    <= scnt_d;
      md_busy_q <= md_busy_d;
      md_wb_q   <= md_wb_d;
    end
  end

  assign md_busy   = md_busy_q;
  assign md_wb     = md_wb_q;
  assign md_rd     = md_rd_q;
  assign stall_cnt = scnt_q;
endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Bench for pl_hazard_ctrl: two configurations driven by shared directed
// stimulus, checked every cycle against a cycle-number based model.
module tb_pl_hazard_ctrl;
  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] d_rs1, d_rs2, d_rd, e_rd, m_rd;
  logic       d_use1, d_use2, d_wreg, d_md;
  logic       e_wreg, e_m2reg, m_wreg, m_m2reg, br_taken;

  logic [1:0]  fwda0, fwdb0, fwda1, fwdb1;
  logic        wp0, bb0, fl0, ms0, mb0, mw0;
  logic        wp1, bb1, fl1, ms1, mb1, mw1;
  logic [4:0]  mrd0, mrd1;
  logic [15:0] sc0;
  logic [1:0]  sc1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pl_hazard_ctrl #(.REG_AW(5), .MD_LAT(8), .LD_EXTRA(0), .SCNT_W(16)) u_dut0 (
    .clk(clk), .clrn(clrn), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1),
    .d_use2(d_use2), .d_rd(d_rd), .d_wreg(d_wreg), .d_md(d_md), .e_rd(e_rd),
    .m_rd(m_rd), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .br_taken(br_taken), .fwda(fwda0), .fwdb(fwdb0),
    .wpcir(wp0), .d_bubble(bb0), .f_flush(fl0), .md_start(ms0), .md_busy(mb0),
    .md_rd(mrd0), .md_wb(mw0), .stall_cnt(sc0));

  pl_hazard_ctrl #(.REG_AW(5), .MD_LAT(3), .LD_EXTRA(1), .SCNT_W(2)) u_dut1 (
    .clk(clk), .clrn(clrn), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1),
    .d_use2(d_use2), .d_rd(d_rd), .d_wreg(d_wreg), .d_md(d_md), .e_rd(e_rd),
    .m_rd(m_rd), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .br_taken(br_taken), .fwda(fwda1), .fwdb(fwdb1),
    .wpcir(wp1), .d_bubble(bb1), .f_flush(fl1), .md_start(ms1), .md_busy(mb1),
    .md_rd(mrd1), .md_wb(mw1), .stall_cnt(sc1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an MD issued in cycle s is busy in cycles s+1..s+LAT and writes back in s+LAT.
  int         lat[2]  = '{8, 3};
  int         ldx[2]  = '{0, 1};
  int         smax[2] = '{65535, 3};
  int         mstart[2];
  logic [4:0] mreg[2];
  int         mscnt[2];

  function automatic bit rd_hit(input logic u, input logic [4:0] r, input logic [4:0] rd);
    return u && r != 0 && r == rd;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic u, input logic [4:0] r, input int lx);
    if (!u || r == 0) return 2'b00;
    if (e_wreg && !e_m2reg && e_rd == r) return 2'b01;
    if (m_wreg && !m_m2reg && m_rd == r) return 2'b10;
    if (m_wreg && m_m2reg && m_rd == r && lx == 0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic mcheck(input int i, input logic [1:0] fa, input logic [1:0] fb,
                        input logic w, input logic b, input logic f, input logic s,
                        input logic bz, input logic [4:0] rd, input logic wb,
                        input logic [15:0] sc);
    bit busy, wbk, ldh, stl, st;
    if (!clrn) begin
      mstart[i] = -1000;
      mreg[i]   = 0;
      mscnt[i]  = 0;
    end
    busy = cyc > mstart[i] && cyc <= mstart[i] + lat[i];
    wbk  = cyc == mstart[i] + lat[i];
    ldh  = e_wreg && e_m2reg && (rd_hit(d_use1, d_rs1, e_rd) || rd_hit(d_use2, d_rs2, e_rd));
    if (ldx[i] != 0)
      ldh = ldh || (m_wreg && m_m2reg &&
                    (rd_hit(d_use1, d_rs1, m_rd) || rd_hit(d_use2, d_rs2, m_rd)));
    stl = ldh || (d_md && busy) ||
          (busy && (rd_hit(d_use1, d_rs1, mreg[i]) || rd_hit(d_use2, d_rs2, mreg[i]))) ||
          (busy && d_wreg && d_rd != 0 && d_rd == mreg[i]);
    st  = d_md && !stl && !br_taken;
    chk($sformatf("m%0d_fwda", i), fa, exp_fwd(d_use1, d_rs1, ldx[i]));
    chk($sformatf("m%0d_fwdb", i), fb, exp_fwd(d_use2, d_rs2, ldx[i]));
    chk($sformatf("m%0d_wpcir", i), w, br_taken || !stl);
    chk($sformatf("m%0d_bubble", i), b, br_taken || stl);
    chk($sformatf("m%0d_flush", i), f, br_taken);
    chk($sformatf("m%0d_md_start", i), s, st);
    chk($sformatf("m%0d_md_busy", i), bz, busy);
    chk($sformatf("m%0d_md_rd", i), rd, mreg[i]);
    chk($sformatf("m%0d_md_wb", i), wb, wbk);
    chk($sformatf("m%0d_stall_cnt", i), sc, mscnt[i]);
    if (clrn) begin
      if (st) begin
        mstart[i] = cyc;
        mreg[i]   = d_rd;
      end
      if (stl && !br_taken && mscnt[i] < smax[i]) mscnt[i]++;
    end
  endtask

  always @(negedge clk) begin
    mcheck(0, fwda0, fwdb0, wp0, bb0, fl0, ms0, mb0, mrd0, mw0, sc0);
    mcheck(1, fwda1, fwdb1, wp1, bb1, fl1, ms1, mb1, mrd1, mw1, {14'b0, sc1});
  end

  task automatic clr_in();
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; e_rd = 0; m_rd = 0;
    d_use1 = 0; d_use2 = 0; d_wreg = 0; d_md = 0;
    e_wreg = 0; e_m2reg = 0; m_wreg = 0; m_m2reg = 0; br_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [15:0] sc_hold;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mstart[i] = -1000; mreg[i] = 0; mscnt[i] = 0;
    end
    clrn = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    neg();
    chk("rst_md_busy", mb0, 0); chk("rst_stall_cnt", sc0, 0);
    chk("rst_md_rd", mrd0, 0);  chk("rst_md_wb", mw0, 0);
    step(); clrn = 1'b1;

    // ALU forwarding: EXE, then MEM, then x0
    clr_in(); e_rd = 5; e_wreg = 1; d_rs1 = 5; d_use1 = 1;
    neg(); chk("fwd_exe", fwda0, 2'b01); chk("fwd_exe_wpcir", wp0, 1);
    step(); clr_in(); m_rd = 5; m_wreg = 1; d_rs1 = 5; d_use1 = 1;
    neg(); chk("fwd_mem0", fwda0, 2'b10); chk("fwd_mem1", fwda1, 2'b10);
    step(); clr_in(); e_rd = 0; e_wreg = 1; d_rs1 = 0; d_use1 = 1;
    neg(); chk("fwd_x0", fwda0, 2'b00);

    // load-use
    step(); clr_in(); e_rd = 6; e_wreg = 1; e_m2reg = 1; d_rs2 = 6; d_use2 = 1;
    neg(); chk("ld_wpcir0", wp0, 0); chk("ld_bubble0", bb0, 1); chk("ld_wpcir1", wp1, 0);
    step(); clr_in(); m_rd = 6; m_wreg = 1; m_m2reg = 1; d_rs2 = 6; d_use2 = 1;
    neg(); chk("ld_fwdb0", fwdb0, 2'b11); chk("ld_go0", wp0, 1);
    chk("ld2_wpcir1", wp1, 0); chk("ld2_fwdb1", fwdb1, 2'b00);
    step(); clr_in(); d_rs2 = 6; d_use2 = 1;
    neg(); chk("ld_go1", wp1, 1); chk("ld_fwdb1", fwdb1, 2'b00);

    // div x7 then dependent add
    step(); clr_in(); d_md = 1; d_rd = 7; d_wreg = 1;
    neg(); chk("div_start", ms0, 1);
    for (int k = 1; k <= 9; k++) begin
      step(); clr_in(); d_rs1 = 7; d_use1 = 1; d_wreg = 1; d_rd = 10;
      neg();
      chk($sformatf("dep_wpcir_t%0d", k), wp0, k == 9);
      chk($sformatf("div_wb_t%0d", k), mw0, k == 8);
      chk($sformatf("div_busy_t%0d", k), mb0, k <= 8);
      if (k == 3) chk("div_wb_lat3", mw1, 1);
    end

    // second div stalled behind the first
    step(); clr_in(); d_md = 1; d_rd = 8; d_wreg = 1;
    neg(); chk("div8_start", ms0, 1);
    for (int k = 1; k <= 9; k++) begin
      step(); clr_in(); d_md = 1; d_rd = 9; d_wreg = 1;
      neg();
      chk($sformatf("div9_start_s%0d", k), ms0, k == 9);
    end
    step(); clr_in(); d_rs1 = 3; d_use1 = 1; d_wreg = 1; d_rd = 4;
    neg(); chk("indep_wpcir", wp0, 1); chk("indep_busy", mb0, 1); chk("indep_md_rd", mrd0, 9);

    // stall and branch together
    step(); clr_in(); d_rs1 = 9; d_use1 = 1; d_md = 1; br_taken = 1;
    neg(); sc_hold = sc0;
    chk("br_wpcir", wp0, 1); chk("br_flush", fl0, 1);
    chk("br_bubble", bb0, 1); chk("br_md_start", ms0, 0);
    step(); clr_in();
    neg(); chk("br_stall_cnt", sc0, sc_hold);

    // reset in the middle of BUSY
    step(); clrn = 1'b0;
    neg(); chk("mid_rst_busy", mb0, 0); chk("mid_rst_cnt", sc0, 0); chk("mid_rst_busy1", mb1, 0);
    repeat (3) step();
    clrn = 1'b1;
    repeat (8) step();

    // long load stall saturates the narrow counter
    clr_in(); e_rd = 6; e_wreg = 1; e_m2reg = 1; d_rs1 = 6; d_use1 = 1;
    repeat (6) step();
    neg(); chk("sat_cnt1", sc1, 3); chk("cnt0_6", sc0, 6);
    step(); clr_in();
    repeat (2) step();
    neg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
